// File: rtl/mat_walk_pkg.sv
// Shared types for the mat_walk strided memory walker: command modes, FSM states
// and the helper that decides whether a mode writes or reads.
package mat_walk_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      FILL_IDX   = 2'd0,
      FILL_CONST = 2'd1,
      READ       = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_RD,
      S_DONE
   } state_e;

   // The reserved encoding falls through to a read.
   function automatic logic mode_is_write(input logic [MODE_W-1:0] m);
      return (m == FILL_IDX) || (m == FILL_CONST);
   endfunction

endpackage

// File: rtl/mat_walk_idx.sv
// Element index counters for mat_walk: i (row), j (column) and the row base address.
// Exposes the post-advance values so the walker can register the next request directly.
module mat_walk_idx
   import mat_walk_pkg::*;
#(
   parameter int MEM_AW   = 16,
   parameter int DIM_BITS = 16
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                advance,
   input  logic [MEM_AW-1:0]   base,
   input  logic [DIM_BITS-1:0] stride,
   input  logic [DIM_BITS-1:0] rows,
   input  logic [DIM_BITS-1:0] cols,
   output logic [DIM_BITS-1:0] nxt_i,
   output logic [DIM_BITS-1:0] nxt_j,
   output logic [MEM_AW-1:0]   nxt_row_addr,
   output logic                last
);

   logic [DIM_BITS-1:0] i_q;
   logic [DIM_BITS-1:0] j_q;
   logic [MEM_AW-1:0]   row_q;
   logic [DIM_BITS-1:0] stride_q;
   logic [DIM_BITS-1:0] rows_q;
   logic [DIM_BITS-1:0] cols_q;
   logic                col_end;

   always_comb begin
      col_end      = ((j_q + DIM_BITS'(1)) == cols_q);
      nxt_j        = col_end ? '0 : (j_q + DIM_BITS'(1));
      nxt_i        = col_end ? (i_q + DIM_BITS'(1)) : i_q;
      nxt_row_addr = col_end ? (row_q + MEM_AW'(stride_q)) : row_q;
      last         = col_end && ((i_q + DIM_BITS'(1)) == rows_q);
   end

   // Clear also captures the region geometry so later command-input changes are harmless.
   always_ff @(posedge clk) begin
      if (rst) begin
         i_q      <= '0;
         j_q      <= '0;
         row_q    <= '0;
         stride_q <= '0;
         rows_q   <= '0;
         cols_q   <= '0;
      end else if (clear) begin
         i_q      <= '0;
         j_q      <= '0;
         row_q    <= base;
         stride_q <= stride;
         rows_q   <= rows;
         cols_q   <= cols;
      end else if (advance) begin
         i_q   <= nxt_i;
         j_q   <= nxt_j;
         row_q <= nxt_row_addr;
      end
   end

endmodule

// File: rtl/mat_walk.sv
// mat_walk: walks a rows x cols region at base with row pitch stride, filling or reading it.
// Optional read checksum accumulator enabled by defining MAT_WALK_CHECKSUM_EN.
module mat_walk
   import mat_walk_pkg::*;
#(
   parameter int MEM_AW   = 16,
   parameter int MEM_DW   = 32,
   parameter int DIM_BITS = 16
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                go,
   input  logic [MODE_W-1:0]   mode,
   input  logic [MEM_AW-1:0]   base,
   input  logic [DIM_BITS-1:0] stride,
   input  logic [DIM_BITS-1:0] rows,
   input  logic [DIM_BITS-1:0] cols,
   input  logic [MEM_DW-1:0]   fill_val,
   output logic                mem_req,
   output logic                mem_write,
   output logic [MEM_AW-1:0]   mem_addr,
   output logic [MEM_DW-1:0]   mem_wdata,
   input  logic                mem_gnt,
   input  logic                mem_rdata_vld,
   input  logic [MEM_DW-1:0]   mem_rdata,
   output logic                busy,
   output logic                done,
   output logic [MEM_DW-1:0]   checksum
);

   state_e              state;
   state_e              state_nxt;
   logic [MODE_W-1:0]   mode_q;
   logic [MEM_DW-1:0]   fill_q;
   logic                req_nxt;
   logic                write_nxt;
   logic [MEM_AW-1:0]   addr_nxt;
   logic [MEM_DW-1:0]   wdata_nxt;
   logic                busy_nxt;
   logic                done_nxt;
   logic                sum_add;
   logic                idx_clear;
   logic                idx_advance;
   logic [DIM_BITS-1:0] nxt_i;
   logic [DIM_BITS-1:0] nxt_j;
   logic [MEM_AW-1:0]   nxt_row_addr;
   logic                last;

   function automatic logic [MEM_DW-1:0] idx_data(input logic [DIM_BITS-1:0] ii,
                                                  input logic [DIM_BITS-1:0] jj);
      return ~(MEM_DW'(ii) + MEM_DW'(jj) + MEM_DW'(1));
   endfunction

   mat_walk_idx #(
      .MEM_AW   (MEM_AW),
      .DIM_BITS (DIM_BITS)
   ) u_idx (
      .clk          (clk),
      .rst          (rst),
      .clear        (idx_clear),
      .advance      (idx_advance),
      .base         (base),
      .stride       (stride),
      .rows         (rows),
      .cols         (cols),
      .nxt_i        (nxt_i),
      .nxt_j        (nxt_j),
      .nxt_row_addr (nxt_row_addr),
      .last         (last)
   );

   // Outputs are registered, so this block computes the values they take after the edge;
   // the request fields hold by default, which keeps them stable while a grant is pending.
   always_comb begin
      state_nxt   = state;
      req_nxt     = mem_req;
      write_nxt   = mem_write;
      addr_nxt    = mem_addr;
      wdata_nxt   = mem_wdata;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      sum_add     = 1'b0;
      idx_clear   = 1'b0;
      idx_advance = 1'b0;
      case (state)
         S_IDLE: begin
            if (go) begin
               idx_clear = 1'b1;
               if ((rows == '0) || (cols == '0)) begin
                  state_nxt = S_DONE;
                  done_nxt  = 1'b1;
                  busy_nxt  = 1'b0;
                  req_nxt   = 1'b0;
               end else begin
                  state_nxt = S_ISSUE;
                  req_nxt   = 1'b1;
                  busy_nxt  = 1'b1;
                  write_nxt = mode_is_write(mode);
                  addr_nxt  = base;
                  wdata_nxt = (mode == FILL_CONST) ? fill_val : idx_data('0, '0);
               end
            end
         end
         S_ISSUE: begin
            if (mem_gnt) begin
               if (mode_is_write(mode_q)) begin
                  idx_advance = 1'b1;
                  if (last) begin
                     state_nxt = S_DONE;
                     req_nxt   = 1'b0;
                     busy_nxt  = 1'b0;
                     done_nxt  = 1'b1;
                  end else begin
                     addr_nxt  = nxt_row_addr + MEM_AW'(nxt_j);
                     wdata_nxt = (mode_q == FILL_CONST) ? fill_q : idx_data(nxt_i, nxt_j);
                  end
               end else begin
                  state_nxt = S_WAIT_RD;
                  req_nxt   = 1'b0;
               end
            end
         end
         S_WAIT_RD: begin
            if (mem_rdata_vld) begin
               sum_add     = 1'b1;
               idx_advance = 1'b1;
               if (last) begin
                  state_nxt = S_DONE;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = S_ISSUE;
                  req_nxt   = 1'b1;
                  addr_nxt  = nxt_row_addr + MEM_AW'(nxt_j);
               end
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         mem_req   <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mode_q    <= '0;
         fill_q    <= '0;
      end else begin
         state     <= state_nxt;
         mem_req   <= req_nxt;
         mem_write <= write_nxt;
         mem_addr  <= addr_nxt;
         mem_wdata <= wdata_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         if (idx_clear) begin
            mode_q <= mode;
            fill_q <= fill_val;
         end
      end
   end

`ifdef MAT_WALK_CHECKSUM_EN
   logic [MEM_DW-1:0] sum_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q <= '0;
      end else if (idx_clear) begin
         sum_q <= '0;
      end else if (sum_add) begin
         sum_q <= sum_q + mem_rdata;
      end
   end

   assign checksum = sum_q;
`else
   logic unused_rdata;

   assign unused_rdata = ^{mem_rdata, sum_add};
   assign checksum     = '0;
`endif

endmodule

// File: tb/tb_mat_walk.sv
// Directed testbench for mat_walk: a per-cycle vector table for the fill walks plus
// hand-written read, empty-region and mid-command reset sequences.
module tb_mat_walk;
   import mat_walk_pkg::*;

   localparam int MEM_AW   = 16;
   localparam int MEM_DW   = 32;
   localparam int DIM_BITS = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic                go;
   logic [1:0]          mode;
   logic [MEM_AW-1:0]   base;
   logic [DIM_BITS-1:0] stride;
   logic [DIM_BITS-1:0] rows;
   logic [DIM_BITS-1:0] cols;
   logic [MEM_DW-1:0]   fill_val;
   logic                mem_req;
   logic                mem_write;
   logic [MEM_AW-1:0]   mem_addr;
   logic [MEM_DW-1:0]   mem_wdata;
   logic                mem_gnt;
   logic                mem_rdata_vld;
   logic [MEM_DW-1:0]   mem_rdata;
   logic                busy;
   logic                done;
   logic [MEM_DW-1:0]   checksum;

   always #5 clk = ~clk;

   mat_walk #(
      .MEM_AW   (MEM_AW),
      .MEM_DW   (MEM_DW),
      .DIM_BITS (DIM_BITS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .go            (go),
      .mode          (mode),
      .base          (base),
      .stride        (stride),
      .rows          (rows),
      .cols          (cols),
      .fill_val      (fill_val),
      .mem_req       (mem_req),
      .mem_write     (mem_write),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_gnt       (mem_gnt),
      .mem_rdata_vld (mem_rdata_vld),
      .mem_rdata     (mem_rdata),
      .busy          (busy),
      .done          (done),
      .checksum      (checksum)
   );

   // One record per cycle: expectations for the outputs visible in that cycle,
   // then the go/gnt values driven during it.
   typedef struct {
      logic        go;
      logic        gnt;
      logic        exp_req;
      logic        exp_done;
      logic        exp_busy;
      logic        chk_data;
      logic [15:0] exp_addr;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t        vecs[$];
   int          vec_count = 0;
   int          miss_count = 0;
   logic [15:0] rd_addr[4] = '{16'h0200, 16'h0201, 16'h0210, 16'h0211};
   logic [15:0] wrap_addr[2] = '{16'hFFFF, 16'h0000};
   logic [31:0] wrap_data[2] = '{32'd7, 32'd9};
   logic [15:0] empty_rows[2] = '{16'd0, 16'd3};
   logic [15:0] empty_cols[2] = '{16'd5, 16'd0};
   logic [31:0] exp_sum_rd;
   logic [31:0] exp_sum_wrap;

   function automatic vec_t mk(input logic g, input logic gt, input logic rq, input logic dn,
                               input logic bz, input logic cd, input logic [15:0] a,
                               input logic [31:0] w);
      vec_t v;
      v.go        = g;
      v.gnt       = gt;
      v.exp_req   = rq;
      v.exp_done  = dn;
      v.exp_busy  = bz;
      v.chk_data  = cd;
      v.exp_addr  = a;
      v.exp_wdata = w;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_count++;
      if (act !== exp) begin
         miss_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic g, input logic gt, input logic v, input logic [31:0] rd);
      go            = g;
      mem_gnt       = gt;
      mem_rdata_vld = v;
      mem_rdata     = rd;
   endtask

   task automatic set_cmd(input logic [1:0] m, input logic [15:0] b, input logic [15:0] s,
                          input logic [15:0] r, input logic [15:0] c, input logic [31:0] f);
      mode     = m;
      base     = b;
      stride   = s;
      rows     = r;
      cols     = c;
      fill_val = f;
   endtask

   task automatic check_idle_zero(input string tag);
      checkOutput({tag, ".req"}, 32'(mem_req), 32'd0);
      checkOutput({tag, ".write"}, 32'(mem_write), 32'd0);
      checkOutput({tag, ".addr"}, 32'(mem_addr), 32'd0);
      checkOutput({tag, ".wdata"}, mem_wdata, 32'd0);
      checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
      checkOutput({tag, ".done"}, 32'(done), 32'd0);
      checkOutput({tag, ".checksum"}, checksum, 32'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
`ifdef MAT_WALK_CHECKSUM_EN
      exp_sum_rd   = 32'd10;
      exp_sum_wrap = 32'd16;
`else
      exp_sum_rd   = 32'd0;
      exp_sum_wrap = 32'd0;
`endif
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      set_cmd(2'd0, '0, '0, '0, '0, '0);
      repeat (2) @(negedge clk);
      check_idle_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // FILL_IDX 2x3 at 0x100, stride 4, grant always high.
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000, 32'h0));
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 16'h0100, 32'hFFFF_FFFE));
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 16'h0101, 32'hFFFF_FFFD));
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 16'h0102, 32'hFFFF_FFFC));
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 16'h0104, 32'hFFFF_FFFD));
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 16'h0105, 32'hFFFF_FFFC));
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 16'h0106, 32'hFFFF_FFFB));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0000, 32'h0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 32'h0));
      // Same command, 2nd request stalled 3 cycles; stray gnt in IDLE and go while busy/done.
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 32'h0));
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 16'h0100, 32'hFFFF_FFFE));
      vecs.push_back(mk(0, 0, 1, 0, 1, 1, 16'h0101, 32'hFFFF_FFFD));
      vecs.push_back(mk(1, 0, 1, 0, 1, 1, 16'h0101, 32'hFFFF_FFFD));
      vecs.push_back(mk(0, 0, 1, 0, 1, 1, 16'h0101, 32'hFFFF_FFFD));
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 16'h0101, 32'hFFFF_FFFD));
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 16'h0102, 32'hFFFF_FFFC));
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 16'h0104, 32'hFFFF_FFFD));
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 16'h0105, 32'hFFFF_FFFC));
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 16'h0106, 32'hFFFF_FFFB));
      vecs.push_back(mk(1, 0, 0, 1, 0, 0, 16'h0000, 32'h0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 32'h0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 32'h0));

      set_cmd(FILL_IDX, 16'h0100, 16'd4, 16'd2, 16'd3, '0);
      for (int k = 0; k < vecs.size(); k++) begin
         checkOutput($sformatf("tbl%0d.req", k), 32'(mem_req), 32'(vecs[k].exp_req));
         checkOutput($sformatf("tbl%0d.done", k), 32'(done), 32'(vecs[k].exp_done));
         checkOutput($sformatf("tbl%0d.busy", k), 32'(busy), 32'(vecs[k].exp_busy));
         if (vecs[k].chk_data) begin
            checkOutput($sformatf("tbl%0d.addr", k), 32'(mem_addr), 32'(vecs[k].exp_addr));
            checkOutput($sformatf("tbl%0d.wdata", k), mem_wdata, vecs[k].exp_wdata);
            checkOutput($sformatf("tbl%0d.write", k), 32'(mem_write), 32'd1);
         end
         applyStimulus(vecs[k].go, vecs[k].gnt, 1'b0, '0);
         @(negedge clk);
      end

      // READ 2x2, data returned two cycles after each grant; stray vld in ISSUE ignored.
      set_cmd(READ, 16'h0200, 16'h0010, 16'd2, 16'd2, '0);
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("rd%0d.req", k), 32'(mem_req), 32'd1);
         checkOutput($sformatf("rd%0d.addr", k), 32'(mem_addr), 32'(rd_addr[k]));
         checkOutput($sformatf("rd%0d.write", k), 32'(mem_write), 32'd0);
         checkOutput($sformatf("rd%0d.busy", k), 32'(busy), 32'd1);
         applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_DEAD);
         @(negedge clk);
         checkOutput($sformatf("rd%0d.req_wait", k), 32'(mem_req), 32'd0);
         applyStimulus(1'b0, 1'b1, 1'b0, '0);
         @(negedge clk);
         applyStimulus(1'b0, 1'b0, 1'b1, 32'(k + 1));
         @(negedge clk);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      checkOutput("rd.done", 32'(done), 32'd1);
      checkOutput("rd.busy", 32'(busy), 32'd0);
      checkOutput("rd.req", 32'(mem_req), 32'd0);
      checkOutput("rd.checksum", checksum, exp_sum_rd);
      @(negedge clk);

      // Reserved mode reads, address wraps past 0xFFFF, zero-latency data.
      set_cmd(2'd3, 16'hFFFF, 16'd1, 16'd1, 16'd2, '0);
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         checkOutput($sformatf("wrap%0d.req", k), 32'(mem_req), 32'd1);
         checkOutput($sformatf("wrap%0d.addr", k), 32'(mem_addr), 32'(wrap_addr[k]));
         checkOutput($sformatf("wrap%0d.write", k), 32'(mem_write), 32'd0);
         applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_1000);
         @(negedge clk);
         checkOutput($sformatf("wrap%0d.req_wait", k), 32'(mem_req), 32'd0);
         applyStimulus(1'b0, 1'b0, 1'b1, wrap_data[k]);
         @(negedge clk);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      checkOutput("wrap.done", 32'(done), 32'd1);
      checkOutput("wrap.checksum", checksum, exp_sum_wrap);
      @(negedge clk);

      // Empty regions complete the cycle after go without any request.
      for (int k = 0; k < 2; k++) begin
         set_cmd(FILL_IDX, 16'h0400, 16'd1, empty_rows[k], empty_cols[k], '0);
         applyStimulus(1'b1, 1'b1, 1'b0, '0);
         @(negedge clk);
         checkOutput($sformatf("empty%0d.done", k), 32'(done), 32'd1);
         checkOutput($sformatf("empty%0d.req", k), 32'(mem_req), 32'd0);
         checkOutput($sformatf("empty%0d.busy", k), 32'(busy), 32'd0);
         applyStimulus(1'b0, 1'b1, 1'b0, '0);
         @(negedge clk);
         checkOutput($sformatf("empty%0d.done_after", k), 32'(done), 32'd0);
         checkOutput($sformatf("empty%0d.req_after", k), 32'(mem_req), 32'd0);
      end

      // FILL_CONST with fill_val changed after go, then reset during the 3rd write.
      set_cmd(FILL_CONST, 16'h0300, 16'd2, 16'd2, 16'd2, 32'hA5A5_0000);
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      @(negedge clk);
      fill_val = 32'h1234_5678;
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      checkOutput("rstw0.addr", 32'(mem_addr), 32'h0300);
      checkOutput("rstw0.wdata", mem_wdata, 32'hA5A5_0000);
      @(negedge clk);
      checkOutput("rstw1.addr", 32'(mem_addr), 32'h0301);
      checkOutput("rstw1.wdata", mem_wdata, 32'hA5A5_0000);
      @(negedge clk);
      checkOutput("rstw2.addr", 32'(mem_addr), 32'h0302);
      checkOutput("rstw2.req", 32'(mem_req), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle_zero("midrst");
      @(negedge clk);
      checkOutput("midrst.req_after", 32'(mem_req), 32'd0);

      set_cmd(FILL_IDX, 16'h0300, 16'd2, 16'd1, 16'd2, '0);
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      checkOutput("restart0.addr", 32'(mem_addr), 32'h0300);
      checkOutput("restart0.wdata", mem_wdata, 32'hFFFF_FFFE);
      @(negedge clk);
      checkOutput("restart1.addr", 32'(mem_addr), 32'h0301);
      checkOutput("restart1.wdata", mem_wdata, 32'hFFFF_FFFD);
      @(negedge clk);
      checkOutput("restart.done", 32'(done), 32'd1);
      checkOutput("restart.req", 32'(mem_req), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule

// File: doc/mat_walk.md
# mat_walk

Parametrised 2D strided memory walker, successor to the single-mode matrix fill engine. It walks a `rows × cols` region at `base` with row pitch `stride` and runs one of three modes per command: fill with the index pattern, fill with a constant, or read back. Unlike its predecessor it honours a memory grant, waits for read data, and reports busy/done plus an optional read checksum. It sits between a command/control register block and the shared single-port memory request bus.

## Interface
Parameters:
- `MEM_AW`, 16: memory address width.
- `MEM_DW`, 32: memory data width.
- `DIM_BITS`, 16: width of rows/cols/stride and of the i/j counters.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous reset, active-high.
- `go`  in  1  command start; sampled only in IDLE.
- `mode`  in  2  0 = FILL_IDX, 1 = FILL_CONST, 2 = READ, 3 = reserved (treated as READ).
- `base`  in  MEM_AW  region start address.
- `stride`  in  DIM_BITS  row pitch in words.
- `rows`, `cols`  in  DIM_BITS  region dimensions.
- `fill_val`  in  MEM_DW  constant for FILL_CONST.
- `mem_req`  out  1  request valid.
- `mem_write`  out  1  1 = write, 0 = read.
- `mem_addr`  out  MEM_AW  request address.
- `mem_wdata`  out  MEM_DW  write data.
- `mem_gnt`  in  1  request accepted this cycle when `mem_req`=1.
- `mem_rdata_vld`  in  1  read data valid.
- `mem_rdata`  in  MEM_DW  read data.
- `busy`  out  1  high from cycle after accepted `go` until DONE.
- `done`  out  1  one-cycle completion pulse.
- `checksum`  out  MEM_DW  sum of read words (see Configuration).

## Operation
- States: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE: on `go`=1, latch all command inputs, clear i, j, row_addr=base, checksum=0. If `rows`==0 or `cols`==0, go to DONE; else ISSUE.
- ISSUE: drive `mem_req`=1, `mem_addr`=row_addr+j (mod 2^MEM_AW), `mem_write`=(mode!=READ). Hold all request fields stable until `mem_gnt`.
  - Write on grant: advance index; if last element go to DONE, else stay in ISSUE with the next address on the following cycle.
  - Read on grant: go to WAIT_RD with `mem_req`=0.
- WAIT_RD: on `mem_rdata_vld`, add `mem_rdata` to checksum (mod 2^MEM_DW), advance index, then ISSUE, or DONE after the last element.
- Index advance: j+1; when j+1==cols, j=0, i+1, row_addr+=stride (zero-extended/truncated to MEM_AW).
- Write data: FILL_IDX = ~(i+j+1) computed at MEM_DW width, i and j zero-extended; FILL_CONST = latched `fill_val`.
- DONE: `done`=1 for one cycle, `busy`=0, return to IDLE.
- `go` outside IDLE is ignored. `mem_rdata_vld` outside WAIT_RD is ignored. `mem_gnt` with `mem_req`=0 is ignored.

## Timing
- Reset: state IDLE; `mem_req`, `mem_write`, `mem_addr`, `mem_wdata`, `busy`, `done`, `checksum` all 0; counters 0. Reset mid-command drops `mem_req` at the next edge and issues no further requests.
- `go` at edge N: `mem_req`=1 from cycle N+1, or `done` at N+1 for an empty region.
- Writes with `mem_gnt` held at 1 sustain one element per cycle; `done` pulses the cycle after the last grant.
- Reads: one outstanding request. With zero-latency `mem_rdata_vld` the minimum is 2 cycles per element.
- All outputs are registered.

## Configuration
- `MAT_WALK_CHECKSUM_EN` defined: checksum accumulator present, behaving as specified above.
- Undefined: no accumulator; `checksum` tied to 0. READ mode still issues all reads and waits for `mem_rdata_vld`.

## Structure
- `mat_walk_pkg`: mode enum (FILL_IDX, FILL_CONST, READ), state enum, mode width constant.
- Sub-module `mat_walk_idx`: i/j/row_addr counters with `clear`, `advance`, and `last` outputs.

## Test plan
- FILL_IDX, base=0x100, stride=4, rows=2, cols=3, gnt=1 → addrs 0x100, 0x101, 0x102, 0x104, 0x105, 0x106 on 6 consecutive cycles; wdata ~1, ~2, ~3, ~2, ~3, ~4; `done` on cycle 7.
- Same command with gnt low for 3 cycles on the 2nd request → addr 0x101/data ~2 held stable for 4 cycles; no skipped or duplicated element.
- READ, rows=2, cols=2, rdata 1, 2, 3, 4 with 2-cycle latency → 4 reads, checksum 10 (0 without macro); `busy` low with `done`.
- rows=0, cols=5 → no `mem_req`; `done` the cycle after `go`.
- `rst` asserted during the 3rd write → next cycle `mem_req`=0 and all outputs 0; a new `go` restarts from base.
- `go` pulsed while busy → ignored; the command completes with its original element count.
